// File: rtl/enemy_formation.sv
// Enemy formation engine: triangle-wave sweep, per-enemy alive bits with hit handshake,
// and a serial one-entry-per-clock position scan for the renderer and collision logic.
module enemy_formation #(
    parameter int unsigned ROWS     = 3,
    parameter int unsigned COLS     = 5,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned CENTER_X = 302,
    parameter int unsigned CENTER_Y = 108,
    parameter int unsigned GAP_X    = 72,
    parameter int unsigned GAP_Y    = 60,
    parameter int unsigned SWEEP    = 72
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stage_start,
    input  logic                   frame_tick,
    input  logic                   hit_valid,
    input  logic [IDX_W-1:0]       hit_index,
    output logic                   hit_ack,
    output logic                   hit_ok,
    output logic                   busy,
    output logic                   pos_valid,
    output logic [IDX_W-1:0]       pos_index,
    output logic [X_W-1:0]         pos_x,
    output logic [Y_W-1:0]         pos_y,
    output logic                   pos_alive,
    output logic [ROWS*COLS-1:0]   alive_mask,
    output logic                   all_dead,
    output logic [1:0]             phase
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned TW = $clog2(SWEEP);

    logic [TW-1:0]    tick_q, tick_d;
    logic [1:0]       phase_q, phase_d;
    logic [N-1:0]     alive_q, alive_d;
    logic             all_dead_q, all_dead_d;
    logic             hit_ack_q, hit_ack_d;
    logic             hit_ok_q, hit_ok_d;
    logic             busy_q, busy_d;
    logic             pos_valid_q, pos_valid_d;
    logic [IDX_W-1:0] pos_index_q, pos_index_d;
    logic [X_W-1:0]   pos_x_q, pos_x_d;
    logic [Y_W-1:0]   pos_y_q, pos_y_d;
    logic             pos_alive_q, pos_alive_d;

    logic             emit;
    logic [IDX_W-1:0] emit_idx;
    int               row_i, col_i, disp_i, base_x_i, x_i, y_i;

    always_comb begin
        tick_d      = tick_q;
        phase_d     = phase_q;
        alive_d     = alive_q;
        hit_ack_d   = 1'b0;
        hit_ok_d    = 1'b0;
        emit        = 1'b0;
        emit_idx    = '0;
        pos_index_d = pos_index_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        pos_alive_d = pos_alive_q;
        row_i       = 0;
        col_i       = 0;
        disp_i      = 0;
        base_x_i    = 0;
        x_i         = 0;
        y_i         = 0;

        if (stage_start) begin
            tick_d  = '0;
            phase_d = '0;
            alive_d = '1;
        end else begin
            if (hit_valid) begin
                hit_ack_d = 1'b1;
                for (int unsigned k = 0; k < N; k++) begin
                    if (hit_index == IDX_W'(k) && alive_q[k]) begin
                        alive_d[k] = 1'b0;
                        hit_ok_d   = 1'b1;
                    end
                end
            end
            if (busy_q) begin
                if (pos_index_q != IDX_W'(N - 1)) begin
                    emit     = 1'b1;
                    emit_idx = pos_index_q + IDX_W'(1);
                end
            end else if (frame_tick) begin
                if (tick_q == TW'(SWEEP - 1)) begin
                    tick_d  = '0;
                    phase_d = phase_q + 2'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
                emit = 1'b1;
            end
        end

        // Entries are built from the post-update motion and post-hit alive state, so a hit
        // landing this cycle already shows on every entry emitted after the current one.
        if (emit) begin
            row_i = int'(emit_idx) / int'(COLS);
            col_i = int'(emit_idx) % int'(COLS);
            unique case (phase_d)
                2'd0:    disp_i = int'(tick_d);
                2'd1:    disp_i = int'(SWEEP) - int'(tick_d);
                2'd2:    disp_i = -int'(tick_d);
                default: disp_i = int'(tick_d) - int'(SWEEP);
            endcase
            base_x_i = int'(CENTER_X) + (col_i - int'((COLS - 1) / 2)) * int'(GAP_X);
            x_i      = row_i[0] ? base_x_i + disp_i : base_x_i - disp_i;
            y_i      = int'(CENTER_Y) + (row_i - int'((ROWS - 1) / 2)) * int'(GAP_Y);
            pos_index_d = emit_idx;
            pos_alive_d = alive_d[emit_idx];
            pos_x_d     = pos_alive_d ? x_i[X_W-1:0] : '1;
            pos_y_d     = pos_alive_d ? y_i[Y_W-1:0] : '1;
        end

        busy_d      = emit;
        pos_valid_d = emit;
        all_dead_d  = (alive_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q      <= '0;
            phase_q     <= '0;
            alive_q     <= '1;
            all_dead_q  <= 1'b0;
            hit_ack_q   <= 1'b0;
            hit_ok_q    <= 1'b0;
            busy_q      <= 1'b0;
            pos_valid_q <= 1'b0;
            pos_index_q <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            pos_alive_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            phase_q     <= phase_d;
            alive_q     <= alive_d;
            all_dead_q  <= all_dead_d;
            hit_ack_q   <= hit_ack_d;
            hit_ok_q    <= hit_ok_d;
            busy_q      <= busy_d;
            pos_valid_q <= pos_valid_d;
            pos_index_q <= pos_index_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            pos_alive_q <= pos_alive_d;
        end
    end

    assign hit_ack    = hit_ack_q;
    assign hit_ok     = hit_ok_q;
    assign busy       = busy_q;
    assign pos_valid  = pos_valid_q;
    assign pos_index  = pos_index_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign pos_alive  = pos_alive_q;
    assign alive_mask = alive_q;
    assign all_dead   = all_dead_q;
    assign phase      = phase_q;

endmodule

// File: doc/enemy_formation.md
# enemy_formation

Sequential enemy-formation engine for the shooter game's stage logic. Holds a ROWS×COLS grid of enemies, advances a four-phase triangle-wave horizontal sweep on each frame tick, tracks per-enemy alive state with a hit handshake, and streams every enemy's position serially (one per clock) to the renderer and collision logic, so no wide parallel position bus is needed on pins.

## Interface
- ROWS, 3, formation rows
- COLS, 5, formation columns; N = ROWS*COLS enemies, index k = r*COLS + c
- IDX_W, 4, index width; must satisfy 2^IDX_W ≥ N
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- CENTER_X, 302, x of the grid centre column at zero displacement
- CENTER_Y, 108, y of the grid centre row
- GAP_X, 72, column pitch
- GAP_Y, 60, row pitch
- SWEEP, 72, ticks per phase; peak displacement = SWEEP
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stage_start  in  1  pulse: revive all enemies, restart motion, abort scan
- frame_tick  in  1  pulse: advance motion one step and start a scan
- hit_valid  in  1  hit request
- hit_index  in  IDX_W  enemy index being hit
- hit_ack  out  1  one-cycle pulse: hit request consumed
- hit_ok  out  1  valid with hit_ack: 1 = a live enemy was killed
- busy  out  1  scan in progress
- pos_valid  out  1  current pos_* entry valid
- pos_index  out  IDX_W  index of current entry
- pos_x  out  X_W  enemy x (all ones if dead)
- pos_y  out  Y_W  enemy y (all ones if dead)
- pos_alive  out  1  entry's alive bit
- alive_mask  out  N  registered alive bits, bit k = enemy k
- all_dead  out  1  alive_mask == 0
- phase  out  2  current motion phase

## Operation
- Motion state: tick t (0..SWEEP-1), phase p (0..3). Displacement d: p0 = +t, p1 = SWEEP−t, p2 = −t, p3 = −(SWEEP−t); continuous triangle wave.
- Accepted frame_tick: t←t+1; at t = SWEEP−1, t←0 and p←p+1 mod 4. Scan then starts using the updated t/p.
- Position of enemy (r,c): base_x = CENTER_X + (c − (COLS−1)/2)·GAP_X; y = CENTER_Y + (r − (ROWS−1)/2)·GAP_Y (integer division). Even rows x = base_x − d, odd rows x = base_x + d. Arithmetic is signed, at least X_W+2 bits, truncated to X_W; parameters must keep every coordinate in range (no clamping).
- Dead enemy: pos_x, pos_y all ones, pos_alive = 0; entry is still emitted.
- Scan: entries k = 0..N−1 in ascending order, one per cycle, no gaps. t/p are frozen during scan (no frame_tick accepted).
- frame_tick while busy = 1: ignored entirely (no motion advance, no rescan).
- Hit: hit_valid sampled every cycle, no backpressure. If hit_index < N and alive: clear bit, hit_ok = 1. If out of range or already dead: no state change, hit_ok = 0. hit_ack pulses for every hit_valid.
- Hit during scan: entry emitted in the same cycle as the hit shows pre-hit alive state; later entries show post-hit state.
- stage_start: alive_mask ← all ones, t ← 0, p ← 0, scan aborted (busy, pos_valid ← 0); a same-cycle frame_tick or hit_valid is dropped (no hit_ack).
- Priority: reset > stage_start > frame_tick/hit.

## Timing
- Reset values: alive_mask = all ones, t = 0, phase = 0, all_dead = 0, busy = 0, pos_valid = 0, pos_index = 0, pos_x = 0, pos_y = 0, pos_alive = 0, hit_ack = 0, hit_ok = 0.
- frame_tick sampled at edge E (busy = 0): t/p update at E; pos_valid and busy high for cycles E+1 .. E+N with pos_index = 0..N−1; busy low at E+N+1. A frame_tick sampled at the edge ending cycle E+N (busy = 1) is ignored; the earliest accepted tick is sampled at edge E+N+1.
- Hit sampled at edge E: alive_mask, all_dead, hit_ack, hit_ok valid in cycle E+1.
- stage_start at edge E: all effects visible in cycle E+1.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset, one frame_tick -> 15 consecutive entries; index 0 = (157,48), index 5 = (159,108), index 14 = (445,168), all pos_alive = 1, busy low after.
- 72 frame_ticks spaced > 16 cycles -> phase = 1, index 0 x = 86; 288 ticks -> phase = 0, index 0 x = 158.
- hit_index = 7 -> hit_ack, hit_ok = 1, alive_mask bit 7 = 0; next scan index 7 = (1023,511), pos_alive = 0; repeat hit 7 -> hit_ok = 0; hit_index = 15 -> hit_ok = 0, mask unchanged.
- Hit index 3 in the cycle index 3 is emitted -> that entry pos_alive = 1; hit index 9 during same scan -> entry 9 pos_alive = 0.
- frame_tick held high continuously -> exactly one accepted tick per N+1 cycles, t advances by one per accepted tick.
- Kill all 15 -> all_dead = 1; stage_start mid-scan -> busy = 0 next cycle, alive_mask = 0x7FFF, phase = 0, all_dead = 0.
